load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-side initiator for the MIPS datapath. It accepts byte/halfword/word load and store requests on byte addresses and converts them into the word-wide, single-port `datamemory` access protocol (`addr`, `din`, `rw`, registered read output). Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended. The block sits between the EX/MEM stage and the data memory.

## Interface
Parameters:
- `ADDR_BITS`, 10: word-address width driven to memory (1k words).
- `WORD`, 32: data width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend loads (ignored for word and for stores).
- `req_addr` in 32: byte address.
- `req_wdata` in WORD: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out WORD: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned or reserved-size request; qualified by `rsp_valid`.
- `mem_addr` out ADDR_BITS: `req_addr[ADDR_BITS+1:2]`, held for the whole operation.
- `mem_din` out WORD: write data to memory.
- `mem_rw` out 1: 1 = write, 0 = read.
- `mem_dout` in WORD: registered memory read output. It is valid in the cycle after the edge that read it and holds while `mem_rw` = 1.

## Operation
- Little-endian lanes: byte lane `req_addr[1:0]`, lane 0 = bits [7:0]. Half lane `req_addr[1]`. Address bits above `ADDR_BITS+1` are ignored, so addresses wrap.
- A handshake occurs at an edge where `req_valid & req_ready`. Request fields are registered at that edge. `req_ready` = `rst_n` & (state == IDLE).
- States:
  - IDLE
  - RD: `mem_rw`=0; the memory reads at the next edge.
  - LCAP: format `mem_dout`; register the response; go to IDLE.
  - WR: `mem_rw`=1, `mem_din`=`req_wdata`; go to IDLE.
  - MRG: `mem_rw`=1, `mem_din` = `mem_dout` with the target lane(s) replaced; go to IDLE.
  - ERR: no memory access; go to IDLE.
- Transitions out of IDLE on handshake:
  - Error → ERR.
  - Load → RD, then LCAP.
  - Word store → WR.
  - Byte/half store → RD, then MRG.
- Errors: half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11.
- Load formatting: select the lane and extend. Sign uses bit 7 or bit 15 when `req_signed`=1; otherwise zero-fill.
- `mem_rw` is gated by `rst_n`, so no memory write occurs at any edge where `rst_n`=0. Outside WR/MRG, `mem_rw`=0.
- No response backpressure.

## Timing
- Handshake at edge E0. `rsp_valid` is registered and high for exactly one cycle:
  - Error: after E1.
  - Word store: after E1; the memory writes at E1.
  - Load: after E2; the memory reads at E1 and `mem_dout` is sampled at E2.
  - Sub-word store: after E2; read at E1, merged write at E2.
- `req_ready` rises in the same cycle as `rsp_valid`. Back-to-back requests are accepted with no bubble.
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_rw`=0, `mem_addr`=0, `mem_din`=0.
- Reset mid-operation: the operation is aborted at that edge and no response is issued. A store in WR or MRG is not written at the reset edge.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: misalignment and size-11 detection as above.
- `LSU_MISALIGN_CHECK_EN` undefined:
  - `rsp_err` is tied 0 and the ERR state is removed.
  - Half ignores `addr[0]`, word ignores `addr[1:0]`, and size 11 is treated as word.

## Test plan
- Preload word 1 = 0x8899AABB. `lb` at addr 4, signed → `rsp_rdata` 0xFFFFFFBB, 2 cycles after the handshake edge. Unsigned → 0x000000BB.
- `lh` signed at addr 6 → 0xFFFF8899. `lw` at addr 4 → 0x8899AABB.
- `sb` 0x11 at addr 5 → `mem_rw`=1 only in the MRG cycle, `mem_din`=0x889911BB. A following `lw` at 4 returns 0x889911BB.
- `sw` 0x000007D1 at addr 0 → `rsp_valid` 1 cycle after the handshake edge. A back-to-back `lw` at 0, accepted the same cycle, returns 0x000007D1.
- With `LSU_MISALIGN_CHECK_EN`, `sh` at addr 5 → `rsp_err`=1, `rsp_rdata`=0, `mem_rw` never 1, memory unchanged. Without the macro, the same `sh` writes lane 0–1.
- Assert `rst_n`=0 during the MRG cycle of `sb` → no write (word unchanged), `rsp_valid` stays 0, `req_ready`=1 the cycle after `rst_n` returns high.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for a single-port, registered-read word memory.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (flags misaligned and reserved-size requests on rsp_err).
module load_store_unit #(
  parameter int ADDR_BITS = 10,
  parameter int WORD      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [WORD-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [WORD-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [WORD-1:0]      mem_din,
  output logic                 mem_rw,
  input  logic [WORD-1:0]      mem_dout
);

`ifdef LSU_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_RD = 3'd1, ST_LCAP = 3'd2,
                            ST_WR = 3'd3, ST_MRG = 3'd4, ST_ERR = 3'd5} state_e;
`else
  typedef enum logic [2:0] {ST_IDLE = 3'd0, ST_RD = 3'd1, ST_LCAP = 3'd2,
                            ST_WR = 3'd3, ST_MRG = 3'd4} state_e;
`endif

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [1:0]            lane_q, lane_d;
  logic [WORD-1:0]       wdata_q, wdata_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  hs_s;
  logic                  sub_word_s;
  logic                  unused_addr_s;

  function automatic logic [WORD-1:0] fmt_load(input logic [WORD-1:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   fmt_load = {{(WORD-8){sgn & b[7]}}, b};
      2'b01:   fmt_load = {{(WORD-16){sgn & h[15]}}, h};
      default: fmt_load = word;
    endcase
  endfunction

  function automatic logic [WORD-1:0] merge_store(input logic [WORD-1:0] old, input logic [WORD-1:0] wd,
                                                  input logic [1:0] size, input logic [1:0] lane);
    logic [WORD-1:0] m;
    m = old;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      m[31:16] = wd[15:0];
    end else begin
      m[15:0] = wd[15:0];
    end
    merge_store = m;
  endfunction

  assign hs_s          = (state_q == ST_IDLE) && req_valid;
  assign sub_word_s    = (req_size == 2'b00) || (req_size == 2'b01);
  assign unused_addr_s = ^req_addr[31:ADDR_BITS+2];

`ifdef LSU_MISALIGN_CHECK_EN
  logic req_err_s;
  // Misalignment / reserved-size classification of the incoming request
  always_comb begin
    case (req_size)
      2'b00:   req_err_s = 1'b0;
      2'b01:   req_err_s = req_addr[0];
      2'b10:   req_err_s = (req_addr[1:0] != 2'b00);
      default: req_err_s = 1'b1;
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!hs_s) begin
          state_d = ST_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
        end else if (req_err_s) begin
          state_d = ST_ERR;
`endif
        end else if (!req_we || sub_word_s) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD:   state_d = we_q ? ST_MRG : ST_LCAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and registered response computation
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    if (hs_s) begin
      we_d    = req_we;
      size_d  = req_size;
      sgn_d   = req_signed;
      lane_d  = req_addr[1:0];
      wdata_d = req_wdata;
      addr_d  = req_addr[ADDR_BITS+1:2];
    end else begin
      addr_d  = addr_q;
    end
    rsp_valid_d = (state_q == ST_LCAP) || (state_q == ST_WR) || (state_q == ST_MRG);
    rsp_err_d   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    rsp_valid_d = rsp_valid_d || (state_q == ST_ERR);
    rsp_err_d   = (state_q == ST_ERR);
`endif
    if (state_q == ST_LCAP) begin
      rsp_rdata_d = fmt_load(mem_dout, size_q, lane_q, sgn_q);
    end else begin
      rsp_rdata_d = {WORD{1'b0}};
    end
  end

  // Datapath and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= {WORD{1'b0}};
      addr_q      <= {ADDR_BITS{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {WORD{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Output logic; memory write strobe is gated by reset so no write lands on a reset edge
  always_comb begin
    req_ready = rst_n && (state_q == ST_IDLE);
    mem_addr  = addr_q;
    mem_rw    = 1'b0;
    mem_din   = {WORD{1'b0}};
    case (state_q)
      ST_WR: begin
        mem_rw  = rst_n;
        mem_din = wdata_q;
      end
      ST_MRG: begin
        mem_rw  = rst_n;
        mem_din = merge_store(mem_dout, wdata_q, size_q, lane_q);
      end
      default: begin
        mem_rw  = 1'b0;
        mem_din = {WORD{1'b0}};
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a behavioural registered-read word memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_rw;
  logic [31:0] rsp_rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_BITS(10), .WORD(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rw(mem_rw), .mem_dout(mem_dout)
  );

  // Single-port word memory with registered read; preloaded while mem_init is low
  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (mem_init && mem_rw) mem[mem_addr] <= mem_din;
    else mem_dout <= mem[mem_addr];
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h8899AABB;
      mem[2] <= 32'h12345678;
      mem[3] <= 32'hA5A5A5A5;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [31:0] rdata; logic err; int cyc;} rsp_t;
  typedef struct {logic [9:0] addr; logic [31:0] din; int cyc;} wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_pass = 0;
  int   n_total = 0;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic monitor();
    rsp_t r;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
          check("rsp_cycle", cyc, r.cyc);
        end
      end
      if (mem_rw === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("unexpected_mem_write", {31'b0, mem_rw}, 32'h0);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", {22'b0, mem_addr}, {22'b0, w.addr});
          check("wr_din", mem_din, w.din);
          check("wr_cycle", cyc, w.cyc);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_rsp, input logic [31:0] exp_rdata,
                       input logic exp_err, input int lat, input logic exp_wr, input logic [31:0] exp_din);
    int budget;
    int hs;
    budget     = 20;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    while (req_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
    end else begin
      hs = cyc + 1;
      if (exp_rsp) rsp_q.push_back('{exp_rdata, exp_err, hs + lat});
      if (exp_wr) wr_q.push_back('{addr[11:2], exp_din, hs + lat - 1});
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int budget;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("ready_in_reset", {31'b0, req_ready}, 32'h0);
    rst_n = 1'b1;
    mem_init = 1'b1;
    #1;
    check("reset_ready", {31'b0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("reset_mem_rw", {31'b0, mem_rw}, 32'h0);
    check("reset_mem_addr", {22'b0, mem_addr}, 32'h0);
    check("reset_mem_din", mem_din, 32'h0);
    @(negedge clk);

    //    we    size   sgn   addr          wdata         rsp   rdata          err   lat wr    din
    issue(1'b0, 2'b00, 1'b1, 32'h00000004, 32'h0,        1'b1, 32'hFFFFFFBB, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h00000004, 32'h0,        1'b1, 32'h000000BB, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h00000006, 32'h0,        1'b1, 32'hFFFF8899, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h00000006, 32'h0,        1'b1, 32'h00008899, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h00000007, 32'h0,        1'b1, 32'h00000088, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h00000004, 32'h0,        1'b1, 32'h8899AABB, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h00001004, 32'h0,        1'b1, 32'h8899AABB, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h00000005, 32'h00000011, 1'b1, 32'h0,        1'b0, 2, 1'b1, 32'h889911BB);
    issue(1'b0, 2'b00, 1'b1, 32'h00000005, 32'h0,        1'b1, 32'h00000011, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h00000004, 32'h0,        1'b1, 32'h889911BB, 1'b0, 2, 1'b0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h00000000, 32'h000007D1, 1'b1, 32'h0,        1'b0, 1, 1'b1, 32'h000007D1);
    issue(1'b0, 2'b10, 1'b0, 32'h00000000, 32'h0,        1'b1, 32'h000007D1, 1'b0, 2, 1'b0, 32'h0);
    if (CHK) begin
      issue(1'b1, 2'b01, 1'b0, 32'h00000005, 32'h0000CAFE, 1'b1, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h00000004, 32'h0,        1'b1, 32'h889911BB, 1'b0, 2, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h00000002, 32'h0,        1'b1, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      issue(1'b0, 2'b11, 1'b0, 32'h00000008, 32'h0,        1'b1, 32'h0, 1'b1, 1, 1'b0, 32'h0);
    end else begin
      issue(1'b1, 2'b01, 1'b0, 32'h00000005, 32'h0000CAFE, 1'b1, 32'h0, 1'b0, 2, 1'b1, 32'h8899CAFE);
      issue(1'b0, 2'b10, 1'b0, 32'h00000004, 32'h0,        1'b1, 32'h8899CAFE, 1'b0, 2, 1'b0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h00000002, 32'h0,        1'b1, 32'h000007D1, 1'b0, 2, 1'b0, 32'h0);
      issue(1'b0, 2'b11, 1'b0, 32'h00000008, 32'h0,        1'b1, 32'h12345678, 1'b0, 2, 1'b0, 32'h0);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h0000000A, 32'h0000BEEF, 1'b1, 32'h0,        1'b0, 2, 1'b1, 32'hBEEF5678);
    issue(1'b0, 2'b01, 1'b0, 32'h0000000A, 32'h0,        1'b1, 32'h0000BEEF, 1'b0, 2, 1'b0, 32'h0);

    // sb aborted by reset during its merge cycle: nothing is expected from it
    issue(1'b1, 2'b00, 1'b0, 32'h0000000D, 32'h0000003C, 1'b0, 32'h0, 1'b0, 2, 1'b0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mrg_rw_gated_by_reset", {31'b0, mem_rw}, 32'h0);
    @(negedge clk);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'h1);
    check("abort_mem_word3", mem[3], 32'hA5A5A5A5);
    @(negedge clk);
    check("abort_no_late_rsp", {31'b0, rsp_valid}, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 2, 1'b0, 32'h0);

    budget = 20;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (2) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 32'h0);
    check("wr_queue_drained", wr_q.size(), 32'h0);
    check("mem_word0", mem[0], 32'h000007D1);
    check("mem_word1", mem[1], CHK ? 32'h889911BB : 32'h8899CAFE);
    check("mem_word2", mem[2], 32'hBEEF5678);
    check("mem_word3", mem[3], 32'hA5A5A5A5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
